// File: rtl/multi_stock_quote_engine.sv
// multi_stock_quote_engine
// Per-stock market-making quote generator. Top-of-book samples tagged with a
// stock ID update per-stock reference mid and EWMA volatility; quotes are the
// mid widened by base + volatility half-spread and skewed by inventory.
// Fixed latency: a sample accepted at edge N pulses its outputs after edge N+3.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_best_ask, i_best_bid  top-of-book prices (unsigned)
//   i_inventory_state       signed inventory of i_stock_id
//   i_data_valid            sample valid (no backpressure)
//   i_stock_id              stock channel of the sample
//   i_stock_enable          per-stock quoting enable mask
//   o_buy_price/o_sell_price saturated bid/ask quotes (hold between pulses)
//   o_stock_id              stock of the emitted result
//   o_data_valid            quote pulse
//   o_book_error            crossed-book pulse (exclusive with o_data_valid)
module multi_stock_quote_engine #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned INV_WIDTH        = 16,
    parameter int unsigned NUM_STOCKS       = 4,
    parameter int unsigned BASE_HALF_SPREAD = 2,
    parameter int unsigned VOL_SHIFT        = 1,
    parameter int unsigned ALPHA_SHIFT      = 2,
    parameter int unsigned SKEW_GAIN        = 1,
    parameter int unsigned WARMUP_SAMPLES   = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [DATA_WIDTH-1:0]         i_best_ask,
    input  logic [DATA_WIDTH-1:0]         i_best_bid,
    input  logic [INV_WIDTH-1:0]          i_inventory_state,
    input  logic                          i_data_valid,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
    input  logic [NUM_STOCKS-1:0]         i_stock_enable,
    output logic [DATA_WIDTH-1:0]         o_buy_price,
    output logic [DATA_WIDTH-1:0]         o_sell_price,
    output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
    output logic                          o_data_valid,
    output logic                          o_book_error
);

    localparam int unsigned ID_W  = $clog2(NUM_STOCKS);
    localparam int unsigned CNT_W = $clog2(WARMUP_SAMPLES + 1);
    localparam int unsigned QW    = DATA_WIDTH + INV_WIDTH + 2;
    localparam logic [CNT_W-1:0] WARM = CNT_W'(WARMUP_SAMPLES);
    localparam logic signed [QW-1:0] PMAX =
        $signed({{(QW - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}});

    // ---------------- S1: input capture ----------------
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_ask_q, s1_bid_q;
    logic [INV_WIDTH-1:0]  s1_inv_q;
    logic [ID_W-1:0]       s1_id_q;
    logic                  s1_en_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid_q <= 1'b0;
            s1_ask_q   <= '0;
            s1_bid_q   <= '0;
            s1_inv_q   <= '0;
            s1_id_q    <= '0;
            s1_en_q    <= 1'b0;
        end else begin
            s1_valid_q <= i_data_valid;
            if (i_data_valid) begin
                s1_ask_q <= i_best_ask;
                s1_bid_q <= i_best_bid;
                s1_inv_q <= i_inventory_state;
                s1_id_q  <= i_stock_id;
                s1_en_q  <= i_stock_enable[i_stock_id];
            end
        end
    end

    // ---------------- S2: per-stock state read-modify-write ----------------
    logic [DATA_WIDTH-1:0] prev_mid_q [NUM_STOCKS];
    logic [DATA_WIDTH-1:0] vol_q      [NUM_STOCKS];
    logic [CNT_W-1:0]      cnt_q      [NUM_STOCKS];
    logic [NUM_STOCKS-1:0] first_q;

    logic [DATA_WIDTH:0]   sum_c;
    logic [DATA_WIDTH-1:0] mid_c, cur_prev_c, cur_vol_c, diff_c, vol_d;
    logic [CNT_W-1:0]      cur_cnt_c, cnt_d;
    logic                  crossed_c, cur_first_c;

    // Mid at DATA_WIDTH+1 bits so ask+bid cannot overflow before the halving.
    always_comb begin
        sum_c       = {1'b0, s1_ask_q} + {1'b0, s1_bid_q};
        mid_c       = DATA_WIDTH'(sum_c >> 1);
        crossed_c   = s1_bid_q > s1_ask_q;
        cur_prev_c  = prev_mid_q[s1_id_q];
        cur_vol_c   = vol_q[s1_id_q];
        cur_cnt_c   = cnt_q[s1_id_q];
        cur_first_c = first_q[s1_id_q];
        diff_c      = (mid_c >= cur_prev_c) ? (mid_c - cur_prev_c) : (cur_prev_c - mid_c);
    end

    // Next per-stock state; a crossed sample leaves everything untouched.
    always_comb begin
        vol_d = cur_vol_c;
        cnt_d = cur_cnt_c;
        if (!crossed_c) begin
            if (cur_first_c) begin
                cnt_d = CNT_W'(1);
            end else begin
                vol_d = cur_vol_c - (cur_vol_c >> ALPHA_SHIFT) + (diff_c >> ALPHA_SHIFT);
                if (cur_cnt_c < WARM) cnt_d = cur_cnt_c + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(NUM_STOCKS); i++) begin
                prev_mid_q[i] <= '0;
                vol_q[i]      <= '0;
                cnt_q[i]      <= '0;
            end
            first_q <= '1;
        end else if (s1_valid_q && !crossed_c) begin
            prev_mid_q[s1_id_q] <= mid_c;
            vol_q[s1_id_q]      <= vol_d;
            cnt_q[s1_id_q]      <= cnt_d;
            first_q[s1_id_q]    <= 1'b0;
        end
    end

    logic                  s2_quote_q, s2_err_q;
    logic [DATA_WIDTH-1:0] s2_mid_q, s2_vol_q;
    logic [INV_WIDTH-1:0]  s2_inv_q;
    logic [ID_W-1:0]       s2_id_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s2_quote_q <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_mid_q   <= '0;
            s2_vol_q   <= '0;
            s2_inv_q   <= '0;
            s2_id_q    <= '0;
        end else begin
            s2_quote_q <= s1_valid_q && !crossed_c && (cnt_d >= WARM) && s1_en_q;
            s2_err_q   <= s1_valid_q && crossed_c;
            s2_mid_q   <= mid_c;
            s2_vol_q   <= vol_d;
            s2_inv_q   <= s1_inv_q;
            s2_id_q    <= s1_id_q;
        end
    end

    // ---------------- S3: quote arithmetic with saturation ----------------
    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [QW-1:0] v);
        if (v < 0)         return '0;
        else if (v > PMAX) return '1;
        else               return v[DATA_WIDTH-1:0];
    endfunction

    logic signed [QW-1:0] mid_s, half_s, skew_s, inv_s, buy_s, sell_s;

    always_comb begin
        mid_s  = $signed(QW'(s2_mid_q));
        half_s = $signed(QW'(BASE_HALF_SPREAD) + QW'(s2_vol_q >> VOL_SHIFT));
        inv_s  = $signed({{(QW - INV_WIDTH){s2_inv_q[INV_WIDTH-1]}}, s2_inv_q});
        skew_s = inv_s * $signed(QW'(SKEW_GAIN));
        buy_s  = mid_s - half_s - skew_s;
        sell_s = mid_s + half_s - skew_s;
    end

    logic                  s3_quote_q, s3_err_q;
    logic [DATA_WIDTH-1:0] s3_buy_q, s3_sell_q;
    logic [ID_W-1:0]       s3_id_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s3_quote_q <= 1'b0;
            s3_err_q   <= 1'b0;
            s3_buy_q   <= '0;
            s3_sell_q  <= '0;
            s3_id_q    <= '0;
        end else begin
            s3_quote_q <= s2_quote_q;
            s3_err_q   <= s2_err_q;
            s3_buy_q   <= sat(buy_s);
            s3_sell_q  <= sat(sell_s);
            s3_id_q    <= s2_id_q;
        end
    end

    // Output register: prices hold between quote pulses; the ID follows any pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_data_valid <= 1'b0;
            o_book_error <= 1'b0;
            o_buy_price  <= '0;
            o_sell_price <= '0;
            o_stock_id   <= '0;
        end else begin
            o_data_valid <= s3_quote_q;
            o_book_error <= s3_err_q;
            if (s3_quote_q) begin
                o_buy_price  <= s3_buy_q;
                o_sell_price <= s3_sell_q;
            end
            if (s3_quote_q || s3_err_q) o_stock_id <= s3_id_q;
        end
    end

endmodule

// File: tb/tb_multi_stock_quote_engine.sv
// Directed bench for multi_stock_quote_engine: a table of spaced samples with
// hand-computed quotes, then reset-in-flight and back-to-back sequences.
module tb_multi_stock_quote_engine;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_best_ask, i_best_bid;
    logic [15:0] i_inventory_state;
    logic        i_data_valid;
    logic [1:0]  i_stock_id;
    logic [3:0]  i_stock_enable;
    logic [31:0] o_buy_price, o_sell_price;
    logic [1:0]  o_stock_id;
    logic        o_data_valid, o_book_error;

    always #5 i_clk = ~i_clk;

    multi_stock_quote_engine dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_best_ask        (i_best_ask),
        .i_best_bid        (i_best_bid),
        .i_inventory_state (i_inventory_state),
        .i_data_valid      (i_data_valid),
        .i_stock_id        (i_stock_id),
        .i_stock_enable    (i_stock_enable),
        .o_buy_price       (o_buy_price),
        .o_sell_price      (o_sell_price),
        .o_stock_id        (o_stock_id),
        .o_data_valid      (o_data_valid),
        .o_book_error      (o_book_error)
    );

    typedef struct {
        logic [1:0]         id;
        logic [31:0]        ask;
        logic [31:0]        bid;
        logic signed [15:0] inv;
        logic               en;
        logic               exp_dv;
        logic               exp_err;
        logic [31:0]        exp_buy;
        logic [31:0]        exp_sell;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [31:0] held_buy  = '0;
    logic [31:0] held_sell = '0;
    logic [1:0]  held_id   = '0;

    vec_t tbl [13];
    vec_t post[2];
    vec_t b2b [5];

    function automatic vec_t mk(input logic [1:0] id, input logic [31:0] ask,
                                input logic [31:0] bid, input int inv, input logic en,
                                input logic dv, input logic err,
                                input logic [31:0] eb, input logic [31:0] es);
        vec_t v;
        v.id = id; v.ask = ask; v.bid = bid; v.inv = 16'(inv); v.en = en;
        v.exp_dv = dv; v.exp_err = err; v.exp_buy = eb; v.exp_sell = es;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_data_valid      = 1'b1;
        i_stock_id        = v.id;
        i_best_ask        = v.ask;
        i_best_bid        = v.bid;
        i_inventory_state = v.inv;
        i_stock_enable    = 4'hF;
        if (!v.en) i_stock_enable[v.id] = 1'b0;
    endtask

    task automatic idle();
        i_data_valid   = 1'b0;
        i_stock_enable = 4'hF;
    endtask

    // Compare outputs against the expected pulse, or against held values if none.
    task automatic check_out(input string name, input vec_t v);
        if (v.exp_dv) begin
            held_buy  = v.exp_buy;
            held_sell = v.exp_sell;
            held_id   = v.id;
        end
        cmp({name, ".dv"},   32'(o_data_valid), 32'(v.exp_dv));
        cmp({name, ".err"},  32'(o_book_error), 32'(v.exp_err));
        cmp({name, ".buy"},  o_buy_price,  held_buy);
        cmp({name, ".sell"}, o_sell_price, held_sell);
        if (v.exp_err) held_id = v.id;
        else           cmp({name, ".id"}, 32'(o_stock_id), 32'(held_id));
    endtask

    // One sample followed by idle cycles; pulse expected exactly 3 edges later.
    task automatic run_spaced(input string name, input vec_t v);
        @(negedge i_clk); drive(v);
        @(negedge i_clk); idle();
        @(negedge i_clk);
        @(negedge i_clk);
        cmp({name, ".early"}, 32'(o_data_valid | o_book_error), 32'd0);
        @(negedge i_clk);
        check_out(name, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        i_best_ask = '0; i_best_bid = '0; i_inventory_state = '0;
        i_data_valid = 1'b0; i_stock_id = '0; i_stock_enable = 4'hF;

        //            id ask          bid          inv en dv err buy         sell
        tbl[0]  = mk(0, 104,         100,         0,  1, 0, 0, 0,          0);
        tbl[1]  = mk(0, 112,         108,         0,  1, 1, 0, 107,        113);
        tbl[2]  = mk(1, 104,         100,         5,  1, 0, 0, 0,          0);
        tbl[3]  = mk(1, 112,         108,         5,  1, 1, 0, 102,        108);
        tbl[4]  = mk(2, 104,         100,        -5,  1, 0, 0, 0,          0);
        tbl[5]  = mk(2, 112,         108,        -5,  1, 1, 0, 112,        118);
        tbl[6]  = mk(2, 100,         101,         0,  1, 0, 1, 0,          0);
        tbl[7]  = mk(2, 104,         100,         0,  1, 1, 0, 98,         106);
        tbl[8]  = mk(3, 2,           0,           0,  1, 0, 0, 0,          0);
        tbl[9]  = mk(3, 2,           0,          10,  1, 1, 0, 0,          0);
        tbl[10] = mk(3, 42,          38,          0,  0, 0, 0, 0,          0);
        tbl[11] = mk(3, 42,          38,          0,  1, 1, 0, 35,         45);
        tbl[12] = mk(0, 32'hFFFFFFFF, 32'hFFFFFFFF, -5, 1, 1, 0, 32'd3758096399, 32'hFFFFFFFF);

        post[0] = mk(0, 104, 100, 0, 1, 0, 0, 0,   0);
        post[1] = mk(0, 112, 108, 0, 1, 1, 0, 107, 113);

        b2b[0]  = mk(1, 104, 100, 0, 1, 0, 0, 0,   0);
        b2b[1]  = mk(1, 112, 108, 0, 1, 1, 0, 107, 113);
        b2b[2]  = mk(3, 104, 100, 0, 1, 0, 0, 0,   0);
        b2b[3]  = mk(1, 120, 116, 0, 1, 1, 0, 114, 122);
        b2b[4]  = mk(3, 112, 108, 0, 1, 1, 0, 107, 113);

        // Reset state
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        cmp("reset.dv",   32'(o_data_valid), 32'd0);
        cmp("reset.err",  32'(o_book_error), 32'd0);
        cmp("reset.buy",  o_buy_price,  32'd0);
        cmp("reset.sell", o_sell_price, 32'd0);
        cmp("reset.id",   32'(o_stock_id), 32'd0);

        // Spaced directed table
        for (int i = 0; i < 13; i++) run_spaced($sformatf("row%0d", i), tbl[i]);

        // Reset with two samples in flight
        @(negedge i_clk); drive(post[0]);
        @(negedge i_clk); drive(post[1]);
        @(negedge i_clk); idle(); i_reset = 1'b1;
        @(negedge i_clk); i_reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            cmp($sformatf("rst_inflight%0d.pulse", i), 32'(o_data_valid | o_book_error), 32'd0);
        end
        cmp("rst_inflight.buy",  o_buy_price,  32'd0);
        cmp("rst_inflight.sell", o_sell_price, 32'd0);
        cmp("rst_inflight.id",   32'(o_stock_id), 32'd0);
        held_buy = '0; held_sell = '0; held_id = '0;

        // Warm-up required again after reset
        for (int i = 0; i < 2; i++) run_spaced($sformatf("post%0d", i), post[i]);

        // Back-to-back interleaved samples on consecutive cycles
        for (int i = 0; i < 9; i++) begin
            @(negedge i_clk);
            if (i >= 4) check_out($sformatf("b2b%0d", i - 4), b2b[i - 4]);
            if (i < 5) drive(b2b[i]);
            else       idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
